// File: rtl/serial_sub.sv
// ============================================================================
// Module   : serial_sub (with leaf cell full_sub)
// Brief    : Bit-serial WIDTH-bit subtractor, d = a - b - bin, LSB first,
//            one bit per clock through a single full_sub cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// One-bit full subtractor: d = a - b - ci, bo = borrow out of this bit.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ ci;
  assign bo = (~a & b) | (~a & ci) | (b & ci);

endmodule

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  // Counter needs to reach WIDTH-1; one spare bit keeps the compare simple.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;

  logic             cell_d;
  logic             cell_bo;

  // The single arithmetic cell: current LSBs plus the stored borrow.
  full_sub u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Control FSM and serial datapath; d/bo update only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end

        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          r_sh_q <= {cell_d, r_sh_q[WIDTH-1:1]};
          brw_q  <= cell_bo;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            // Last bit: publish the fully assembled result directly.
            d_q     <= {cell_d, r_sh_q[WIDTH-1:1]};
            bo_q    <= cell_bo;
            state_q <= DONE;
          end
        end

        DONE: begin
          // Back-to-back start is accepted here without an IDLE gap.
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so start never reaches them combinationally.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Self-checking bench for serial_sub at WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, bin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, bo8;
  logic [7:0]  d8;

  logic        start16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bo16;
  logic [15:0] d16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8)
  );

  serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .d(d16), .bo(bo16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t tbl[6];

  // Reference: plain signed arithmetic; borrow-out is "result went negative".
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int diff;
    diff = int'(x) - int'(y) - int'(c);
    return {diff < 0, diff[7:0]};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    int diff;
    diff = int'(x) - int'(y) - int'(c);
    return {diff < 0, diff[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation and wait (bounded) for its done pulse.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                     output int lat, output int busyc);
    start8 = 1'b1; a8 = x; b8 = y; bin8 = c;
    step();
    start8 = 1'b0;
    lat = 0;
    busyc = 0;
    while (!done8 && lat < 50) begin
      if (busy8) busyc++;
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, busyc, cnt, held_bad;
    logic [8:0]  e8;
    logic [16:0] e16;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    int acc8, acc16, fin8, fin16, cyc;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    tbl[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};

    // Reset state
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_outputs8", {busy8, done8, bo8, d8}, 32'h0);
    chk("reset_outputs16", {busy16, done16, bo16, d16}, 32'h0);

    // Table-driven single operations with latency and pulse-width checks
    for (int i = 0; i < 6; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].bin, lat, busyc);
      chk($sformatf("tbl%0d_done", i), done8, 1);
      chk($sformatf("tbl%0d_latency", i), lat, 8);
      chk($sformatf("tbl%0d_busy_cycles", i), busyc, 8);
      chk($sformatf("tbl%0d_result", i), {bo8, d8}, {tbl[i].eb, tbl[i].ed});
      step();
      chk($sformatf("tbl%0d_done_one_cycle", i), {busy8, done8}, 0);
      chk($sformatf("tbl%0d_hold", i), {bo8, d8}, {tbl[i].eb, tbl[i].ed});
    end

    // Start held during RUN and operands changed mid-run
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; bin8 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'b1;
      step();
    end
    start8 = 1'b0;
    lat = 3;
    while (!done8 && lat < 50) begin step(); lat++; end
    chk("hold_start_latency", lat, 8);
    chk("hold_start_result", {bo8, d8}, 9'h001);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (done8) cnt++; end
    chk("hold_start_single_done", cnt, 0);

    // Back-to-back start in the DONE cycle
    op8(8'h05, 8'h03, 1'b0, lat, busyc);
    chk("b2b_first_result", {done8, bo8, d8}, {1'b1, 9'h002});
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    step();
    start8 = 1'b0;
    chk("b2b_no_idle_gap", busy8, 1);
    held_bad = 0;
    lat = 0;
    while (!done8 && lat < 50) begin
      if (d8 !== 8'h02 || bo8 !== 1'b0) held_bad++;
      step();
      lat++;
    end
    chk("b2b_prev_result_held", held_bad, 0);
    chk("b2b_second_latency", lat, 8);
    chk("b2b_second_result", {bo8, d8}, 9'h00F);
    step();

    // Asynchronous reset in the middle of RUN
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy8, done8, bo8, d8}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (done8 || busy8) cnt++; end
    chk("no_done_after_reset", cnt, 0);
    op8(8'hFF, 8'h01, 1'b0, lat, busyc);
    chk("post_reset_latency", lat, 8);
    chk("post_reset_result", {bo8, d8}, 9'h0FE);
    step();

    // Randomized regression on both widths against the arithmetic model
    acc8 = 0; acc16 = 0; fin8 = 0; fin16 = 0; cyc = 0;
    while ((fin8 < 1000 || fin16 < 1000) && cyc < 60000) begin
      if (done8) begin
        if (q8.size() == 0) chk("rand8_unexpected_done", 1, 0);
        else begin e8 = q8.pop_front(); chk("rand8_result", {bo8, d8}, e8); fin8++; end
      end
      if (done16) begin
        if (q16.size() == 0) chk("rand16_unexpected_done", 1, 0);
        else begin e16 = q16.pop_front(); chk("rand16_result", {bo16, d16}, e16); fin16++; end
      end
      start8 = (acc8 < 1000) && ($urandom_range(0, 3) != 0);
      a8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      b8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      bin8 = 1'($urandom_range(0, 1));
      if (start8 && !busy8) begin q8.push_back(ref8(a8, b8, bin8)); acc8++; end
      start16 = (acc16 < 1000) && ($urandom_range(0, 3) != 0);
      a16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      b16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      bin16 = 1'($urandom_range(0, 1));
      if (start16 && !busy16) begin q16.push_back(ref16(a16, b16, bin16)); acc16++; end
      step();
      cyc++;
    end
    start8 = 1'b0;
    start16 = 1'b0;
    chk("rand8_completed", fin8, 1000);
    chk("rand16_completed", fin16, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first.
- Instantiates the existing full_sub cell once. The block supplies that cell's operand bits and stored borrow each cycle and captures its difference and borrow outputs.
- Sits directly around full_sub: the shift/borrow datapath feeding and consuming the cell, with a start/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block is not busy
- a  input  WIDTH  minuend, latched on an accepted start
- b  input  WIDTH  subtrahend, latched on an accepted start
- bin  input  1  borrow-in, latched on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion pulse
- d  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
- bo  output  1  borrow-out, 1 iff a < b + bin (unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; busy=0, done=0, d=0, bo=0. Internal shift registers, borrow FF and bit counter are all 0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - busy=0, done=0.
  - On start=1 at a rising edge: load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, go to RUN.
- RUN (busy=1):
  - Each cycle, full_sub gets a=a_sh[0], b=b_sh[0], ci=brw.
  - At the edge: a_sh, b_sh shift right by 1. The cell difference shifts into r_sh at the MSB (r_sh shifts right). brw <= cell borrow. cnt <= cnt+1.
  - After WIDTH RUN cycles (cnt reaches WIDTH-1 and that edge occurs): d <= final r_sh, bo <= final borrow, go to DONE.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted, same load as in IDLE).
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from acceptance.
- d and bo change only on the transition into DONE. They hold their values through IDLE and the next RUN until the next completion.
- start while in RUN is ignored. a, b and bin may change freely after acceptance without effect.
- Counter width is clog2(WIDTH)+1 bits. No wrap issue: cnt is reset on every load.
- Reset asserted mid-RUN: immediate return to the reset values, with no done pulse and no update of d/bo. Operation resumes only on a new start after rst_n deasserts.
- Borrow chain: bit i uses the borrow out of bit i-1. Bit 0 uses bin.
- All outputs are registered or decoded from state only. No combinational path from start to busy or done.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> busy for 8 cycles, done pulse at cycle 9, d=0x02, bo=0.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bo=1. Then a=0xFF, b=0xFF, bin=1 -> d=0xFF, bo=1.
- a=0x80, b=0x7F, bin=0 -> d=0x01, bo=0. Hold start high for 3 cycles during RUN -> only one done pulse, and a/b changes mid-run do not alter d.
- Back-to-back: assert start during the DONE cycle with a=0x10, b=0x01 -> busy rises next cycle with no IDLE gap. Second done shows d=0x0F, bo=0. d keeps the previous result until that second done.
- Drop rst_n during RUN cycle 4 -> busy=0, done=0, d=0, bo=0 immediately (asynchronous). No done pulse follows. A fresh start after release completes correctly.
- Random regression, 1000 operands, WIDTH=8 and WIDTH=16 -> {bo,d} matches the reference model (a - b - bin) on every done pulse.
